// File: rtl/mr_accumulator_sequencer_if.sv
// Bus bundle between the accumulator sequencer (master) and its environment:
// instruction handshake, memory port and arithmetic-unit lines.
interface mr_accumulator_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [2:0]        INSTR_OP;
  logic [ADDR_W-1:0] INSTR_ADDR;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_ACK;
  logic              O2;
  logic              O1;
  logic              O0;
  logic [DATA_W-1:0] D_OUT;
  logic [DATA_W-1:0] ACC_OUT;
  logic [DATA_W-1:0] AH_ACC;
  logic              ZFLAG;
  logic              RETIRE;
  logic [15:0]       RETIRED;

  modport master (
    input  INSTR_VALID, INSTR_OP, INSTR_ADDR, MEM_RDATA, MEM_ACK, AH_ACC,
    output INSTR_READY, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA,
           O2, O1, O0, D_OUT, ACC_OUT, ZFLAG, RETIRE, RETIRED
  );

  modport slave (
    output INSTR_VALID, INSTR_OP, INSTR_ADDR, MEM_RDATA, MEM_ACK, AH_ACC,
    input  INSTR_READY, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA,
           O2, O1, O0, D_OUT, ACC_OUT, ZFLAG, RETIRE, RETIRED
  );
endinterface

// File: rtl/mr_accumulator_sequencer.sv
// Instruction sequencer and accumulator holder around the mrarithmeticunit
// datapath: fetches operands, drives the unit, registers its result.
module mr_accumulator_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  mr_accumulator_sequencer_if.master  bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_IDLE  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                zflag_q, zflag_d;
  logic                retire_q, retire_d;
  logic [15:0]         retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    retire_d  = 1'b0;
    retired_d = retired_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.INSTR_VALID) begin
          op_d   = bus.INSTR_OP;
          addr_d = bus.INSTR_ADDR;
          if (bus.INSTR_OP == OP_ADD || bus.INSTR_OP == OP_SUB ||
              bus.INSTR_OP == OP_LOAD) begin
            state_d = S_FETCH;
          end else if (bus.INSTR_OP[2:1] == 2'b01) begin
            state_d = S_EXEC;
          end else if (bus.INSTR_OP == OP_STORE) begin
            state_d = S_WRITE;
          end else begin
            // NOP retires on the accepting edge and never leaves IDLE
            retire_d  = 1'b1;
            retired_d = retired_q + 16'd1;
          end
        end
      end
      S_FETCH: begin
        if (bus.MEM_ACK) begin
          opnd_d  = bus.MEM_RDATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d     = (op_q == OP_LOAD) ? opnd_q : bus.AH_ACC;
        retire_d  = 1'b1;
        retired_d = retired_q + 16'd1;
        state_d   = S_IDLE;
      end
      S_WRITE: begin
        if (bus.MEM_ACK) begin
          retire_d  = 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zflag_d = (acc_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      zflag_q   <= 1'b1;
      retire_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      zflag_q   <= zflag_d;
      retire_q  <= retire_d;
      retired_q <= retired_d;
    end
  end

  logic       in_exec;
  logic [2:0] alu_op;

  assign in_exec = (state_q == S_EXEC);
  assign alu_op  = in_exec ? op_q : OP_IDLE;

  assign bus.INSTR_READY = (state_q == S_IDLE);
  assign bus.MEM_RD      = (state_q == S_FETCH);
  assign bus.MEM_WR      = (state_q == S_WRITE);
  assign bus.MEM_ADDR    = (state_q == S_FETCH || state_q == S_WRITE) ? addr_q : '0;
  assign bus.MEM_WDATA   = (state_q == S_WRITE) ? acc_q : '0;
  assign bus.O2          = alu_op[2];
  assign bus.O1          = alu_op[1];
  assign bus.O0          = alu_op[0];
  // CLR drives a zero operand even though the operand register is stale
  assign bus.D_OUT       = (in_exec && op_q[2:1] != 2'b01) ? opnd_q : '0;
  assign bus.ACC_OUT     = acc_q;
  assign bus.ZFLAG       = zflag_q;
  assign bus.RETIRE      = retire_q;
  assign bus.RETIRED     = retired_q;

endmodule

// File: tb/tb_mr_accumulator_sequencer.sv
// Directed bench for mr_accumulator_sequencer with a behavioural memory and
// arithmetic-unit model; expected values are hand-computed constants.
module tb_mr_accumulator_sequencer;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mr_accumulator_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mr_accumulator_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic        mem_auto = 1'b1;
  logic        force_ack = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  logic [7:0]  last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  int          wr_count = 0;

  // Arithmetic unit model: 000 add, 001 sub, 01x clear, otherwise hold
  logic [2:0] o_bus;
  assign o_bus = {bus.O2, bus.O1, bus.O0};
  always_comb begin
    case (o_bus)
      3'b000:  bus.AH_ACC = bus.ACC_OUT + bus.D_OUT;
      3'b001:  bus.AH_ACC = bus.ACC_OUT - bus.D_OUT;
      3'b010,
      3'b011:  bus.AH_ACC = 16'h0000;
      default: bus.AH_ACC = bus.ACC_OUT;
    endcase
  end

  always_comb begin
    bus.MEM_ACK   = force_ack |
                    (mem_auto && (bus.MEM_RD || bus.MEM_WR) && (wcnt >= ack_delay));
    bus.MEM_RDATA = mem[bus.MEM_ADDR];
  end

  always @(posedge CLK) begin
    if ((bus.MEM_RD || bus.MEM_WR) && !bus.MEM_ACK) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.MEM_WR && bus.MEM_ACK) begin
      last_wr_addr <= bus.MEM_ADDR;
      last_wr_data <= bus.MEM_WDATA;
      wr_count     <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Present an instruction for exactly one edge
  task automatic issue(input logic [2:0] op, input logic [7:0] addr);
    bus.INSTR_VALID = 1'b1;
    bus.INSTR_OP    = op;
    bus.INSTR_ADDR  = addr;
    tick();
    bus.INSTR_VALID = 1'b0;
    bus.INSTR_OP    = 3'b000;
    bus.INSTR_ADDR  = 8'h00;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_ready"},   32'(bus.INSTR_READY), 32'd1);
    check({pfx, "_rd"},      32'(bus.MEM_RD),      32'd0);
    check({pfx, "_wr"},      32'(bus.MEM_WR),      32'd0);
    check({pfx, "_addr"},    32'(bus.MEM_ADDR),    32'd0);
    check({pfx, "_wdata"},   32'(bus.MEM_WDATA),   32'd0);
    check({pfx, "_op"},      32'(o_bus),           32'b110);
    check({pfx, "_dout"},    32'(bus.D_OUT),       32'd0);
    check({pfx, "_acc"},     32'(bus.ACC_OUT),     32'd0);
    check({pfx, "_zflag"},   32'(bus.ZFLAG),       32'd1);
    check({pfx, "_retire"},  32'(bus.RETIRE),      32'd0);
    check({pfx, "_retired"}, 32'(bus.RETIRED),     32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h0005;
    mem[8'h11] = 16'h0007;
    mem[8'h30] = 16'hFFFF;
    mem[8'h31] = 16'h0001;
    mem[8'h32] = 16'h1234;
    mem[8'h33] = 16'h00AA;
    bus.INSTR_VALID = 1'b0;
    bus.INSTR_OP    = 3'b000;
    bus.INSTR_ADDR  = 8'h00;

    // Reset
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    check_reset_state("rst");

    // ADD M[0x10]=5 with zero-wait memory
    issue(3'b000, 8'h10);
    check("add_fetch_ready", 32'(bus.INSTR_READY), 32'd0);
    check("add_fetch_rd",    32'(bus.MEM_RD),      32'd1);
    check("add_fetch_addr",  32'(bus.MEM_ADDR),    32'h10);
    check("add_fetch_op",    32'(o_bus),           32'b110);
    tick();
    check("add_exec_op",     32'(o_bus),           32'b000);
    check("add_exec_dout",   32'(bus.D_OUT),       32'h0005);
    check("add_exec_ready",  32'(bus.INSTR_READY), 32'd0);
    tick();
    check("add_acc",         32'(bus.ACC_OUT),     32'h0005);
    check("add_zflag",       32'(bus.ZFLAG),       32'd0);
    check("add_retire",      32'(bus.RETIRE),      32'd1);
    check("add_ready",       32'(bus.INSTR_READY), 32'd1);

    // SUB M[0x11]=7, accepted 3 cycles after the ADD
    issue(3'b001, 8'h11);
    check("sub_retire_low",  32'(bus.RETIRE),      32'd0);
    tick();
    check("sub_exec_op",     32'(o_bus),           32'b001);
    tick();
    check("sub_acc",         32'(bus.ACC_OUT),     32'hFFFE);
    check("sub_zflag",       32'(bus.ZFLAG),       32'd0);
    check("sub_retired",     32'(bus.RETIRED),     32'd2);
    check("sub_ready",       32'(bus.INSTR_READY), 32'd1);

    // LOAD 0xFFFF then ADD 1: wraps to zero
    issue(3'b100, 8'h30);
    tick();
    check("ld_exec_op",      32'(o_bus),           32'b100);
    tick();
    check("ld_acc",          32'(bus.ACC_OUT),     32'hFFFF);
    issue(3'b000, 8'h31);
    check("wrap_fetch_op",   32'(o_bus),           32'b110);
    check("wrap_fetch_dout", 32'(bus.D_OUT),       32'h0000);
    tick();
    check("wrap_exec_op",    32'(o_bus),           32'b000);
    check("wrap_exec_dout",  32'(bus.D_OUT),       32'h0001);
    tick();
    check("wrap_acc",        32'(bus.ACC_OUT),     32'h0000);
    check("wrap_zflag",      32'(bus.ZFLAG),       32'd1);
    check("wrap_idle_op",    32'(o_bus),           32'b110);
    check("wrap_idle_dout",  32'(bus.D_OUT),       32'h0000);

    // LOAD 0x1234, STORE to 0x20 with 4 wait cycles
    issue(3'b100, 8'h32);
    tick();
    tick();
    check("ld2_acc",         32'(bus.ACC_OUT),     32'h1234);
    ack_delay = 4;
    issue(3'b101, 8'h20);
    for (int i = 0; i < 5; i++) begin
      check("st_wr",         32'(bus.MEM_WR),      32'd1);
      check("st_rd",         32'(bus.MEM_RD),      32'd0);
      check("st_addr",       32'(bus.MEM_ADDR),    32'h20);
      check("st_wdata",      32'(bus.MEM_WDATA),   32'h1234);
      check("st_ready",      32'(bus.INSTR_READY), 32'd0);
      tick();
    end
    check("st_wr_done",      32'(bus.MEM_WR),      32'd0);
    check("st_ready_done",   32'(bus.INSTR_READY), 32'd1);
    check("st_retire",       32'(bus.RETIRE),      32'd1);
    check("st_mem_addr",     32'(last_wr_addr),    32'h20);
    check("st_mem_data",     32'(last_wr_data),    32'h1234);
    check("st_wr_count",     32'(wr_count),        32'd1);
    check("st_acc_kept",     32'(bus.ACC_OUT),     32'h1234);
    ack_delay = 0;

    // LOAD 0x00AA, then CLR
    issue(3'b100, 8'h33);
    tick();
    tick();
    check("ld3_acc",         32'(bus.ACC_OUT),     32'h00AA);
    check("ld3_zflag",       32'(bus.ZFLAG),       32'd0);
    issue(3'b010, 8'h33);
    check("clr_rd",          32'(bus.MEM_RD),      32'd0);
    check("clr_exec_op",     32'(o_bus),           32'b010);
    check("clr_exec_dout",   32'(bus.D_OUT),       32'h0000);
    tick();
    check("clr_acc",         32'(bus.ACC_OUT),     32'h0000);
    check("clr_zflag",       32'(bus.ZFLAG),       32'd1);
    check("clr_ready",       32'(bus.INSTR_READY), 32'd1);
    check("clr_retired",     32'(bus.RETIRED),     32'd8);

    // LOAD 0x1234 again, reset mid-FETCH of an ADD, then a stray ACK
    issue(3'b100, 8'h32);
    tick();
    tick();
    check("ld4_acc",         32'(bus.ACC_OUT),     32'h1234);
    mem_auto = 1'b0;
    issue(3'b000, 8'h10);
    tick();
    check("rf_rd",           32'(bus.MEM_RD),      32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_reset_state("rf");
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check_reset_state("rf_ack");
    tick();
    check_reset_state("rf_late");
    mem_auto = 1'b1;

    // 65537 back-to-back NOPs
    bus.INSTR_VALID = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.INSTR_OP = (i % 2 == 0) ? 3'b110 : 3'b111;
      tick();
      check("nop_retire",    32'(bus.RETIRE),      32'd1);
      check("nop_retired",   32'(bus.RETIRED),     32'((i + 1) % 65536));
    end
    bus.INSTR_VALID = 1'b0;
    check("nop_final",       32'(bus.RETIRED),     32'h0001);
    check("nop_acc",         32'(bus.ACC_OUT),     32'h0000);
    check("nop_ready",       32'(bus.INSTR_READY), 32'd1);
    check("nop_rd",          32'(bus.MEM_RD),      32'd0);
    tick();
    check("nop_retire_end",  32'(bus.RETIRE),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
